// File: rtl/bcd_encoder_seq.sv
// Iterative binary-to-BCD encoder (shift-and-add-3), one bit per clock,
// with valid/ready handshakes on both the input and the result side.
package bcd_encoder_seq_pkg;

  // Number of decimal digits needed to hold 2^n - 1.
  function automatic int bcd_digits(input int n);
    logic [127:0] v;
    int           d;
    v = (128'd1 << n) - 128'd1;
    d = 0;
    for (int i = 0; i < 128; i++) begin
      if (v != 128'd0) begin
        v = v / 128'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

module bcd_encoder_seq
  import bcd_encoder_seq_pkg::*;
#(
  parameter int  N      = 8,
  parameter bit  SIGNED = 1'b0,
  localparam int D      = bcd_digits(N)
) (
  input  logic           clk,
  input  logic           aresetn,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_bin,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [4*D-1:0] o_bcd,
  output logic           o_sign
);

  localparam int BW = 4 * D;
  localparam int W  = BW + N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    work;
  logic [W-1:0]    work_nxt;
  logic [CW-1:0]   cnt;
  logic            sign_q;

  // Digit correction: any digit >= 5 would overflow past 9 when doubled.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] bcd);
    logic [BW-1:0] r;
    r = bcd;
    for (int i = 0; i < D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Two's-complement magnitude; the most negative value maps to 2^(N-1).
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] bin);
    logic signed [N-1:0] s;
    s = $signed(bin);
    if (SIGNED && (s < 0)) return $unsigned(-s);
    return bin;
  endfunction

  assign work_nxt = {add3(work[W-1:N]), work[N-1:0]} << 1;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load on accept, iterate in SHIFT, publish the result on the last shift.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      work   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      o_bcd  <= '0;
      o_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work   <= {{BW{1'b0}}, magnitude(i_bin)};
            cnt    <= CW'(N);
            sign_q <= SIGNED && i_bin[N-1];
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_bcd  <= work_nxt[W-1:N];
            o_sign <= sign_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_encoder_seq.sv
// Directed and swept checks of bcd_encoder_seq in three configurations:
// 8-bit unsigned, 16-bit unsigned and 8-bit signed.
module tb_bcd_encoder_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   acc_a[$];

  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_ovalid, a_iready, a_sign;
  logic [7:0]  a_bin;
  logic [11:0] a_bcd;

  logic        b_valid, b_ready, b_ovalid, b_iready, b_sign;
  logic [15:0] b_bin;
  logic [19:0] b_bcd;

  logic        c_valid, c_ready, c_ovalid, c_iready, c_sign;
  logic [7:0]  c_bin;
  logic [11:0] c_bcd;

  bcd_encoder_seq #(.N(8), .SIGNED(1'b0)) dut_a (
    .clk(clk), .aresetn(rst_n), .i_valid(a_valid), .o_ready(a_ready),
    .i_bin(a_bin), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_bcd(a_bcd), .o_sign(a_sign)
  );

  bcd_encoder_seq #(.N(16), .SIGNED(1'b0)) dut_b (
    .clk(clk), .aresetn(rst_n), .i_valid(b_valid), .o_ready(b_ready),
    .i_bin(b_bin), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_bcd(b_bcd), .o_sign(b_sign)
  );

  bcd_encoder_seq #(.N(8), .SIGNED(1'b1)) dut_c (
    .clk(clk), .aresetn(rst_n), .i_valid(c_valid), .o_ready(c_ready),
    .i_bin(c_bin), .o_valid(c_ovalid), .i_ready(c_iready),
    .o_bcd(c_bcd), .o_sign(c_sign)
  );

  // Cycle counter and accept-edge log for the 8-bit unsigned instance.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && a_valid && a_ready) acc_a.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [39:0] ref_bcd(input int unsigned v);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Drive one word into dut_a once it is idle and wait (bounded) for the result.
  task automatic run_a(input logic [7:0] v, output logic [11:0] bcd,
                       output logic sgn, output int lat, output bit rdy_hi);
    int guard = 0;
    while (!a_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a_bin   = v;
    a_valid = 1'b1;
    lat     = 0;
    rdy_hi  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    while (!a_ovalid && lat < 40) begin
      if (a_ready) rdy_hi = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (a_ready) rdy_hi = 1'b1;
    bcd = a_bcd;
    sgn = a_sign;
  endtask

  task automatic run_b(input logic [15:0] v, output logic [19:0] bcd, output int lat);
    int guard = 0;
    while (!b_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    b_bin   = v;
    b_valid = 1'b1;
    lat     = 0;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    while (!b_ovalid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    bcd = b_bcd;
  endtask

  task automatic run_c(input logic [7:0] v, output logic [11:0] bcd,
                       output logic sgn, output int lat);
    int guard = 0;
    while (!c_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    c_bin   = v;
    c_valid = 1'b1;
    lat     = 0;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    while (!c_ovalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bcd = c_bcd;
    sgn = c_sign;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_bin = '0; a_iready = 1'b0;
    b_valid = 1'b0; b_bin = '0; b_iready = 1'b1;
    c_valid = 1'b0; c_bin = '0; c_iready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    tests++;
    if (a_ovalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", a_ovalid); end
    tests++;
    if (a_bcd !== 12'h000) begin fails++; $display("FAIL reset_bcd: got %h expected 000", a_bcd); end
    tests++;
    if (c_sign !== 1'b0 || b_ready !== 1'b1) begin
      fails++; $display("FAIL reset_others: got sign=%b b_ready=%b expected 0/1", c_sign, b_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max_unsigned();
    logic [11:0] bcd; logic sgn; int lat; bit rdy_hi;
    a_iready = 1'b0;
    run_a(8'd255, bcd, sgn, lat, rdy_hi);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL max_latency: got %0d expected 8", lat); end
    tests++;
    if (bcd !== 12'h255) begin fails++; $display("FAIL max_bcd: got %h expected 255", bcd); end
    tests++;
    if (sgn !== 1'b0) begin fails++; $display("FAIL max_sign: got %b expected 0", sgn); end
    tests++;
    if (rdy_hi) begin fails++; $display("FAIL max_ready_busy: got 1 expected 0"); end
    a_iready = 1'b1;
    @(negedge clk);
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
      fails++; $display("FAIL max_release: got valid=%b ready=%b expected 0/1", a_ovalid, a_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bcd0, bcd1; logic sgn; int lat0, lat1; bit r0, r1; int n0;
    a_iready = 1'b1;
    n0 = acc_a.size();
    run_a(8'd0, bcd0, sgn, lat0, r0);
    run_a(8'd9, bcd1, sgn, lat1, r1);
    tests++;
    if (bcd0 !== 12'h000) begin fails++; $display("FAIL b2b_first: got %h expected 000", bcd0); end
    tests++;
    if (bcd1 !== 12'h009) begin fails++; $display("FAIL b2b_second: got %h expected 009", bcd1); end
    tests++;
    if (r0 || r1) begin fails++; $display("FAIL b2b_ready_busy: got %b%b expected 00", r0, r1); end
    tests++;
    if (acc_a.size() != n0 + 2) begin
      fails++; $display("FAIL b2b_accepts: got %0d expected %0d", acc_a.size() - n0, 2);
    end else if (acc_a[n0+1] - acc_a[n0] != 10) begin
      fails++; $display("FAIL b2b_interval: got %0d expected 10", acc_a[n0+1] - acc_a[n0]);
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    logic [19:0] bcd; int lat;
    logic [15:0] vin [3] = '{16'hFFFF, 16'd10000, 16'd1};
    logic [19:0] vexp[3] = '{20'h65535, 20'h10000, 20'h00001};
    b_iready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_b(vin[i], bcd, lat);
      tests++;
      if (bcd !== vexp[i] || lat !== 16) begin
        fails++;
        $display("FAIL wide_%0d: got bcd=%h lat=%0d expected bcd=%h lat=16", i, bcd, lat, vexp[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random_sweep();
    logic [19:0] bcd; logic [39:0] exp_full; logic [15:0] v; int lat;
    b_iready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom);
      run_b(v, bcd, lat);
      exp_full = ref_bcd(int'(v));
      tests++;
      if (bcd !== exp_full[19:0]) begin
        fails++; $display("FAIL sweep_%0d: input %0d got %h expected %h", i, v, bcd, exp_full[19:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [11:0] bcd; logic sgn; int lat;
    logic [7:0]  vin [5] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'hF6};
    logic [11:0] vbcd[5] = '{12'h128, 12'h001, 12'h127, 12'h000, 12'h010};
    logic        vsgn[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    c_iready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_c(vin[i], bcd, sgn, lat);
      tests++;
      if (bcd !== vbcd[i] || sgn !== vsgn[i]) begin
        fails++;
        $display("FAIL signed_%h: got bcd=%h sign=%b expected bcd=%h sign=%b",
                 vin[i], bcd, sgn, vbcd[i], vsgn[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [11:0] bcd; logic sgn; int lat; bit rdy_hi; int n0;
    a_iready = 1'b0;
    run_a(8'd123, bcd, sgn, lat, rdy_hi);
    tests++;
    if (bcd !== 12'h123) begin fails++; $display("FAIL bp_result: got %h expected 123", bcd); end
    n0 = acc_a.size();
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a_bin   = 8'(i * 37 + 1);
      @(negedge clk);
      tests++;
      if (a_ovalid !== 1'b1 || a_bcd !== 12'h123 || a_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: got valid=%b bcd=%h ready=%b expected 1/123/0",
                 i, a_ovalid, a_bcd, a_ready);
      end
    end
    a_valid  = 1'b0;
    a_iready = 1'b1;
    @(negedge clk);
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_bcd !== 12'h123) begin
      fails++;
      $display("FAIL bp_release: got valid=%b ready=%b bcd=%h expected 0/1/123",
               a_ovalid, a_ready, a_bcd);
    end
    tests++;
    if (acc_a.size() != n0) begin
      fails++; $display("FAIL bp_no_accept: got %0d accepts expected 0", acc_a.size() - n0);
    end
  endtask

  task automatic test_reset_midconv();
    logic [11:0] bcd; logic sgn; int lat; bit rdy_hi; bit seen;
    a_iready = 1'b1;
    a_bin    = 8'd200;
    a_valid  = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_bcd !== 12'h000) begin
      fails++;
      $display("FAIL midreset_now: got valid=%b ready=%b bcd=%h expected 0/1/000",
               a_ovalid, a_ready, a_bcd);
    end
    tests++;
    if (c_sign !== 1'b0) begin fails++; $display("FAIL midreset_sign: got %b expected 0", c_sign); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_ovalid) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL midreset_no_result: got 1 expected 0"); end
    run_a(8'd42, bcd, sgn, lat, rdy_hi);
    tests++;
    if (bcd !== 12'h042 || lat !== 8) begin
      fails++; $display("FAIL midreset_fresh: got bcd=%h lat=%0d expected 042/8", bcd, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max_unsigned();
    test_back_to_back();
    test_wide();
    test_random_sweep();
    test_signed();
    test_backpressure();
    test_reset_midconv();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_encoder_seq.md
Name: bcd_encoder_seq

Overview:
- Iterative (one bit per clock) binary-to-BCD encoder using shift-and-add-3 (double dabble).
- Parametrised in input width and signedness.
- Uses valid/ready handshakes on input and output, so it drops into streaming datapaths (display drivers, UART number formatting) without the deep combinational cone of a fully unrolled encoder.
- Trades latency of N cycles for roughly constant area per digit.

Parameters:
- N, 8, input binary width in bits (N >= 4).
- SIGNED, 0, 0: i_bin is unsigned. 1: i_bin is two's complement; magnitude is encoded and the sign is reported on o_sign.
- D (localparam, not overridable), derived, number of BCD digits = smallest d with 10^d > 2^N - 1, computed by a constant function. Examples: N=8 gives 3, N=16 gives 5, N=32 gives 10.

Ports:
- clk  input  1  clock, all state on rising edge
- aresetn  input  1  asynchronous, active-low reset
- i_valid  input  1  input word valid
- o_ready  output  1  block can accept an input word
- i_bin  input  N  binary value, sampled on accept
- o_valid  output  1  o_bcd/o_sign hold a completed result
- i_ready  input  1  downstream accepts result
- o_bcd  output  4*D  packed BCD, digit 0 (units) in [3:0]
- o_sign  output  1  1 = negative input (SIGNED=1 only; constant 0 when SIGNED=0)

Behaviour:
- Reset (aresetn low, asynchronous):
  - state = IDLE; o_ready = 1; o_valid = 0; o_bcd = 0; o_sign = 0.
  - Internal shift register and bit counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready = 1.
  - Accept happens on the rising edge where i_valid && o_ready.
  - On accept, load the magnitude into the binary part of the working register and clear the BCD part.
  - Magnitude: SIGNED=0 uses i_bin. SIGNED=1 uses i_bin[N-1] ? -i_bin : i_bin, taken as N-bit unsigned; -2^(N-1) gives 2^(N-1) exactly.
  - Latch the sign; set counter = N; go to SHIFT.
- SHIFT:
  - o_ready = 0.
  - Each edge: every BCD digit >= 5 gets +3 (all digits in parallel, 4-bit wrap never occurs), then the whole {bcd, bin} register shifts left 1; counter decrements.
  - When the counter reaches 0 after the N-th shift: copy the BCD part to o_bcd, copy the sign to o_sign, set o_valid = 1, go to DONE.
- DONE:
  - o_valid = 1; o_ready = 0.
  - o_bcd/o_sign must be stable while o_valid && !i_ready.
  - On an edge with i_ready: o_valid = 0, go to IDLE.
- Latency and throughput:
  - Accept on edge k; o_valid is high after edge k+N.
  - Minimum accept-to-accept interval is N+2 cycles (no overlap of input and output phases).
- i_valid is ignored while o_ready = 0; i_bin is don't-care except at accept.
- o_bcd/o_sign retain the last result after o_valid drops, until the next DONE entry overwrites them.
- Reset asserted mid-SHIFT or mid-DONE aborts the conversion. All outputs return to reset values, and no partial result is ever presented.
- Width rule: the working register is 4*D + N bits. No digit ever exceeds 9 after correction, so the result is exact for all 2^N inputs.

Test Plan:
- N=8, SIGNED=0, i_bin=8'd255 -> o_valid rises exactly 8 cycles after accept; o_bcd=12'h255; o_sign=0.
- N=8, i_bin=0, then i_bin=8'd9 back-to-back with i_ready=1 -> o_bcd=12'h000, then 12'h009. Second accept occurs no earlier than 10 cycles after the first. o_ready is low throughout SHIFT/DONE.
- N=16, i_bin=16'hFFFF -> o_bcd=20'h65535 after 16 cycles. Random sweep of 1000 values checked against a reference model.
- N=8, SIGNED=1: i_bin=8'h80 -> o_sign=1, o_bcd=12'h128. i_bin=8'hFF -> o_sign=1, o_bcd=12'h001. i_bin=8'h7F -> o_sign=0, o_bcd=12'h127.
- Backpressure: i_ready held low 5 cycles in DONE with i_valid=1 and a changing i_bin -> o_valid stays 1, o_bcd is unchanged, no new accept. Releasing i_ready returns the block to IDLE on the next edge.
- Reset mid-conversion: pulse aresetn low asynchronously (mid-cycle) 3 cycles after accept -> o_valid=0, o_bcd=0, o_ready=1 immediately. A fresh conversion of 8'd42 afterwards yields 12'h042.
